// File: rtl/pdm_playback_ctrl.sv
// Sample sequencer for a PDM modulator: FIFO-buffered 7-bit samples released once per sample period.
// Optional UNDERFLOW_CNT_EN adds a saturating underflow_count output.
module pdm_playback_ctrl #(
  parameter int         CLKS_PER_SAMPLE = 128,
  parameter int         DEPTH           = 16,
  parameter int         PRIME_LEVEL     = 8,
  parameter logic [6:0] IDLE_LEVEL      = 7'd64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic [6:0]               s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [6:0]               sample_out,
  output logic                     sample_strobe,
  output logic                     underflow,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
`ifdef UNDERFLOW_CNT_EN
  ,
  output logic [15:0]              underflow_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CLKS_PER_SAMPLE);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_PLAY  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [6:0]     mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [6:0]     sample_q, sample_d;
  logic           strobe_q, strobe_d;
  logic           uf_q, uf_d;
  logic           rdy_en_q;
  logic           push, pop, tick, running, empty, full;

  // Handshake: a sample transfers on a rising clk edge where s_valid && s_ready;
  // s_ready depends only on registered occupancy, never on a same-cycle pop.
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign s_ready = rdy_en_q && !full;
  assign push    = s_valid && s_ready;
  assign running = (state_q == ST_PLAY) || (state_q == ST_DRAIN);
  assign tick    = running && (cnt_q == CW'(CLKS_PER_SAMPLE - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sample_d = sample_q;
    strobe_d = 1'b0;
    uf_d     = 1'b0;
    pop      = 1'b0;
    if (running) cnt_d = tick ? '0 : cnt_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_PRIME;
      end
      ST_PRIME: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (count_q >= (AW+1)'(PRIME_LEVEL)) begin
          state_d = ST_PLAY;
          cnt_d   = CW'(CLKS_PER_SAMPLE - 1);
        end
      end
      ST_PLAY: begin
        if (tick) begin
          if (!empty) begin
            pop      = 1'b1;
            sample_d = mem_q[rd_ptr_q];
            strobe_d = 1'b1;
          end else begin
            uf_d = 1'b1;
          end
        end
        if (stop) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (tick) begin
          if (!empty) begin
            pop      = 1'b1;
            sample_d = mem_q[rd_ptr_q];
            strobe_d = 1'b1;
          end else begin
            state_d  = ST_IDLE;
            sample_d = IDLE_LEVEL;
            strobe_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cnt_q    <= '0;
      sample_q <= IDLE_LEVEL;
      strobe_q <= 1'b0;
      uf_q     <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cnt_q    <= cnt_d;
      sample_q <= sample_d;
      strobe_q <= strobe_d;
      uf_q     <= uf_d;
      rdy_en_q <= 1'b1;
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_data;
  end

  assign sample_out    = sample_q;
  assign sample_strobe = strobe_q;
  assign underflow     = uf_q;
  assign busy          = (state_q != ST_IDLE);
  assign level         = count_q;

`ifdef UNDERFLOW_CNT_EN
  logic [15:0] uf_cnt_q, uf_cnt_d;

  always_comb begin
    uf_cnt_d = uf_cnt_q;
    if ((state_q == ST_IDLE) && start) begin
      uf_cnt_d = '0;
    end else if (uf_d && (uf_cnt_q != 16'hFFFF)) begin
      uf_cnt_d = uf_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) uf_cnt_q <= '0;
    else        uf_cnt_q <= uf_cnt_d;
  end

  assign underflow_count = uf_cnt_q;
`endif

endmodule

// File: tb/tb_pdm_playback_ctrl.sv
// Bench for pdm_playback_ctrl: queue-based reference model checked every cycle, plus directed
// scenarios with literal expectations. Honours UNDERFLOW_CNT_EN when defined.
module tb_pdm_playback_ctrl;

  localparam int CPS   = 128;
  localparam int DEPTH = 16;
  localparam int PRIME = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop, s_valid;
  logic [6:0] s_data;
  logic       s_ready, sample_strobe, underflow, busy;
  logic [6:0] sample_out;
  logic [4:0] level;
`ifdef UNDERFLOW_CNT_EN
  logic [15:0] underflow_count;
`endif

  pdm_playback_ctrl #(
    .CLKS_PER_SAMPLE(CPS),
    .DEPTH(DEPTH),
    .PRIME_LEVEL(PRIME),
    .IDLE_LEVEL(7'd64)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .stop(stop),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .sample_out(sample_out),
    .sample_strobe(sample_strobe),
    .underflow(underflow),
    .busy(busy),
    .level(level)
`ifdef UNDERFLOW_CNT_EN
    ,
    .underflow_count(underflow_count)
`endif
  );

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;

  int    total = 0;
  int    bad   = 0;
  bit    chk_en = 1'b0;
  longint tcyc = 0;

  always @(posedge clk) tcyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // exp_q holds the samples the FIFO must contain; mode 0 idle, 1 prime, 2 play, 3 drain.
  // Sample periods are derived from the absolute cycle at which playback began.
  logic [6:0] exp_q[$];
  int         m_mode = 0;
  longint     m_cyc = 0;
  longint     m_origin = 0;
  logic [6:0] m_sample = 7'd64;
  bit         m_strobe = 1'b0;
  bit         m_uf = 1'b0;
  bit         m_rdy_en = 1'b0;
  int         m_ucnt = 0;

  always @(posedge clk or negedge rst_n) begin : model
    int old_mode;
    int old_size;
    bit tk;
    bit acc;
    if (!rst_n) begin
      exp_q.delete();
      m_mode   = 0;
      m_sample = 7'd64;
      m_strobe = 1'b0;
      m_uf     = 1'b0;
      m_rdy_en = 1'b0;
      m_ucnt   = 0;
    end else begin
      old_mode = m_mode;
      old_size = exp_q.size();
      acc = s_valid && m_rdy_en && (old_size < DEPTH);
      tk  = (old_mode >= 2) && (((m_cyc - m_origin) % CPS) == 0);
      m_strobe = 1'b0;
      m_uf     = 1'b0;
      if (tk) begin
        if (old_size > 0) begin
          m_sample = exp_q.pop_front();
          m_strobe = 1'b1;
        end else if (old_mode == 2) begin
          m_uf = 1'b1;
          if (m_ucnt < 65535) m_ucnt++;
        end else begin
          m_mode   = 0;
          m_sample = 7'd64;
          m_strobe = 1'b1;
        end
      end
      case (old_mode)
        0: if (start) begin m_mode = 1; m_ucnt = 0; end
        1: begin
          if (stop) m_mode = 0;
          else if (old_size >= PRIME) begin m_mode = 2; m_origin = m_cyc + 1; end
        end
        2: if (stop) m_mode = 3;
        default: ;
      endcase
      if (acc) exp_q.push_back(s_data);
      m_rdy_en = 1'b1;
      m_cyc++;
    end
  end

  // ---------------- scoreboard compare (every cycle) ----------------
  always @(negedge clk) begin
    if (chk_en && rst_n === 1'b1) begin
      check("cmp_sample_out", 32'(sample_out), 32'(m_sample));
      check("cmp_strobe", 32'(sample_strobe), 32'(m_strobe));
      check("cmp_underflow", 32'(underflow), 32'(m_uf));
      check("cmp_busy", 32'(busy), 32'(m_mode != 0));
      check("cmp_level", 32'(level), 32'(exp_q.size()));
      check("cmp_s_ready", 32'(s_ready), 32'(m_rdy_en && (exp_q.size() < DEPTH)));
`ifdef UNDERFLOW_CNT_EN
      check("cmp_uf_count", 32'(underflow_count), 32'(m_ucnt));
`endif
    end
  end

  // Output logs used by the directed literal checks.
  logic [6:0] log_v[$];
  longint     log_t[$];
  logic [6:0] uf_v[$];
  logic       uf_s[$];

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (sample_strobe === 1'b1) begin
        log_v.push_back(sample_out);
        log_t.push_back(tcyc);
      end
      if (underflow === 1'b1) begin
        uf_v.push_back(sample_out);
        uf_s.push_back(sample_strobe);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
  endtask

  task automatic push(input logic [6:0] v, input int budget);
    int n;
    n = 0;
    @(negedge clk); s_data = v; s_valid = 1'b1;
    while (s_ready !== 1'b1 && n < budget) begin
      @(negedge clk); n++;
    end
    if (n >= budget) check("push_timeout", 0, 1);
    @(negedge clk); s_valid = 1'b0;
  endtask

  task automatic wait_log(input int n, input int budget);
    int k;
    k = 0;
    while (log_v.size() < n && k < budget) begin
      @(negedge clk); #1; k++;
    end
    if (log_v.size() < n) check("strobe_timeout", 32'(log_v.size()), 32'(n));
  endtask

  task automatic wait_uf(input int n, input int budget);
    int k;
    k = 0;
    while (uf_v.size() < n && k < budget) begin
      @(negedge clk); #1; k++;
    end
    if (uf_v.size() < n) check("underflow_timeout", 32'(uf_v.size()), 32'(n));
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < budget) begin
      @(negedge clk); #1; k++;
    end
    if (busy !== 1'b0) check("idle_timeout", 32'(busy), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=running want=finished t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int base;
    int n;
    start = 1'b0; stop = 1'b0; s_valid = 1'b0; s_data = '0;
    rst_n = 1'b0;
    cyc_wait(5);
    check("rst_sample_out", 32'(sample_out), 64);
    check("rst_s_ready", 32'(s_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_strobe", 32'(sample_strobe), 0);
    check("rst_underflow", 32'(underflow), 0);
    check("rst_level", 32'(level), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    check("idle_s_ready", 32'(s_ready), 1);
    check("idle_level", 32'(level), 0);
    check("idle_sample_out", 32'(sample_out), 64);
    check("idle_busy", 32'(busy), 0);

    // start with an empty FIFO parks in PRIME; stop returns to IDLE silently
    base = log_v.size();
    pulse_start();
    cyc_wait(20);
    check("prime_busy", 32'(busy), 1);
    check("prime_no_strobe", 32'(log_v.size()), 32'(base));
    pulse_stop();
    cyc_wait(2);
    check("prime_stop_idle", 32'(busy), 0);
    check("prime_stop_no_strobe", 32'(log_v.size()), 32'(base));

    // prime with 0..7 and play them at the sample rate
    for (int i = 0; i < 8; i++) push(7'(i), 10);
    check("primed_level", 32'(level), 8);
    base = log_v.size();
    pulse_start();
    wait_log(base + 8, 1200);
    for (int i = 0; i < 8; i++) begin
      if (log_v.size() > base + i) check("play_value", 32'(log_v[base+i]), 32'(i));
      if (i > 0 && log_t.size() > base + i)
        check("play_spacing", 32'(log_t[base+i] - log_t[base+i-1]), CPS);
    end

    // ninth period has nothing to play
    n = uf_v.size();
    wait_uf(n + 1, 200);
    if (uf_v.size() > n) begin
      check("uf_hold_value", 32'(uf_v[n]), 7);
      check("uf_no_strobe", 32'(uf_s[n]), 0);
    end
    check("uf_strobe_count", 32'(log_v.size()), 32'(base + 8));
`ifdef UNDERFLOW_CNT_EN
    check("uf_count_one", 32'(underflow_count), 1);
`endif
    pulse_stop();
    wait_idle(300);
    check("uf_drain_strobes", 32'(log_v.size()), 32'(base + 9));
    if (log_v.size() > base + 8) check("uf_drain_idle_value", 32'(log_v[base+8]), 64);

    // stop with three samples left: they drain, then midscale
    for (int i = 0; i < 8; i++) push(7'(10 + i), 10);
    base = log_v.size();
    pulse_start();
    wait_log(base + 5, 800);
    check("drain_level", 32'(level), 3);
    pulse_stop();
    wait_idle(600);
    check("drain_strobes", 32'(log_v.size()), 32'(base + 9));
    for (int i = 0; i < 9; i++)
      if (log_v.size() > base + i)
        check("drain_value", 32'(log_v[base+i]), (i < 8) ? 32'(10 + i) : 64);
    check("drain_sample_out", 32'(sample_out), 64);
    check("drain_busy", 32'(busy), 0);

    // fill to DEPTH, hold a 17th push across the first pop
    for (int i = 0; i < 16; i++) push(7'(20 + i), 10);
    check("full_level", 32'(level), 16);
    check("full_s_ready", 32'(s_ready), 0);
    base = log_v.size();
    @(negedge clk); s_data = 7'd36; s_valid = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    #1;
    n = 0;
    while (s_ready !== 1'b1 && n < 400) begin
      @(negedge clk); #1; n++;
    end
    check("held_push_after_first_pop", 32'(log_v.size() - base), 1);
    @(negedge clk); s_valid = 1'b0;
    wait_log(base + 2, 300);
    repeat (127) @(negedge clk);
    check("pre_pushpop_level", 32'(level), 15);
    s_data = 7'd37; s_valid = 1'b1;
    @(negedge clk); s_valid = 1'b0;
    #1;
    check("pushpop_level", 32'(level), 15);
    check("pushpop_strobes", 32'(log_v.size()), 32'(base + 3));
    pulse_stop();
    wait_idle(2500);
    check("full_order_count", 32'(log_v.size()), 32'(base + 19));
    for (int i = 0; i < 19; i++)
      if (log_v.size() > base + i)
        check("full_order_value", 32'(log_v[base+i]), (i < 18) ? 32'(20 + i) : 64);

    // asynchronous reset in the middle of playback
    for (int i = 0; i < 8; i++) push(7'(40 + i), 10);
    pulse_start();
    cyc_wait(300);
    check("midplay_busy", 32'(busy), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_sample_out", 32'(sample_out), 64);
    check("async_busy", 32'(busy), 0);
    check("async_s_ready", 32'(s_ready), 0);
    cyc_wait(3);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_level", 32'(level), 0);
    check("post_reset_s_ready", 32'(s_ready), 1);
    check("post_reset_busy", 32'(busy), 0);
    cyc_wait(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
